vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Raster timing generator that sits directly upstream of the VGA shader stage on the 120 MHz system clock. It divides the clock into a pixel strobe and produces the pixel position, the active-video flag, the sync pulses and the frame/line markers. The shader consumes these to compute per-pixel colour. Default timing is 640x480@60 with a 24 MHz pixel rate (120/5).

Parameters:
CLK_DIV, 5, iCLK cycles per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level
VS_POL, 0, vsync asserted level

Ports:
iCLK  input  1  system clock (120 MHz)
iRESETn  input  1  asynchronous active-low reset
iENABLE  input  1  run enable; low = hold idle
oPIX_EN  output  1  one-iCLK strobe; position outputs are new and valid this cycle
oX  output  11  horizontal counter 0..H_TOTAL-1
oY  output  11  vertical counter 0..V_TOTAL-1
oACTIVE  output  1  high when oX<H_ACTIVE and oY<V_ACTIVE
oHSYNC  output  1  horizontal sync, polarity HS_POL
oVSYNC  output  1  vertical sync, polarity VS_POL
oLINE_START  output  1  pulse with oPIX_EN when oX becomes 0
oFRAME_START  output  1  pulse with oPIX_EN when (oX,oY) becomes (0,0)
oFRAME_CNT  output  16  frame number, for shader animation

Behaviour:
- Clock and reset: one clock, iCLK. iRESETn is asynchronous and active-low.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be <= 2048.
- Divider: counter div runs 0..CLK_DIV-1. tick = (div==CLK_DIV-1). With CLK_DIV=1, tick is high every enabled cycle.
- Position counters: internal h and v advance only on tick.
  - h increments. At H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps from V_TOTAL-1 to 0.
- Output registers: all outputs are registered and updated on the tick edge from the next (h,v), so they are mutually consistent.
  - oPIX_EN is high in the first cycle the new values appear, then low for CLK_DIV-1 cycles.
- oHSYNC = HS_POL when H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1, else ~HS_POL.
- oVSYNC uses the same rule on v with V_ACTIVE+V_FP and V_SYNC.
- Line/frame markers: oLINE_START and oFRAME_START are high only in the oPIX_EN cycle of h=0 (and v=0 for frame start); low otherwise.
- oFRAME_CNT increments (mod 2^16) on every frame start.
- Reset (asynchronous):
  - Internal state: div=0, h=H_TOTAL-1, v=V_TOTAL-1, oFRAME_CNT=16'hFFFF.
  - Outputs: oX=0, oY=0, oACTIVE=0, oPIX_EN=0, oLINE_START=0, oFRAME_START=0, oHSYNC=~HS_POL, oVSYNC=~VS_POL.
  - The first tick after release lands on (0,0) with oFRAME_START=1 and oFRAME_CNT=0. It occurs CLK_DIV cycles after release.
  - Reset mid-frame takes effect immediately with no partial-line completion.
- iENABLE low (synchronous):
  - Next edge: div, h, v, and all outputs except oFRAME_CNT go to their reset values. oFRAME_CNT holds.
  - Rising iENABLE behaves as reset release. oFRAME_CNT continues, incrementing at the first (0,0).
- Simultaneous events: at the end of a frame, the h wrap, v wrap, line start, frame start and counter increment all occur on the same tick.

Test Plan:
1. Release reset with default params and iENABLE=1 -> first oPIX_EN 5 iCLK after release, with oX=0, oY=0, oACTIVE=1, oLINE_START=1, oFRAME_START=1, oFRAME_CNT=0. oPIX_EN period is 5 cycles.
2. Run one line -> 800 strobes per line (4000 iCLK). oHSYNC is low for exactly 96 strobes, oX=656..751. oACTIVE is high for oX=0..639 only. oX wraps 799->0 with oY+1.
3. Run one full frame -> 525 lines; oVSYNC low only on oY=490..491. Frame = 420000 strobes = 2,100,000 iCLK; 307200 strobes have oACTIVE=1. Next oFRAME_START shows oFRAME_CNT=1.
4. Assert iRESETn low asynchronously at oX=300, oY=200 -> outputs take reset values before the next edge. After release, restart at (0,0) with oFRAME_CNT=0.
5. Drop iENABLE for 100 cycles mid-frame with oFRAME_CNT=3 -> outputs held at idle values and oFRAME_CNT stays 3. After re-enable, first strobe is at (0,0) after 5 cycles with oFRAME_START=1 and oFRAME_CNT=4.
6. Override CLK_DIV=1 and all porch/sync params =1, with active 2x1 (H_TOTAL=5, V_TOTAL=4) -> oPIX_EN is continuously high after the first cycle. oFRAME_CNT wraps FFFF->0000 after 65536 frames (1,310,720 cycles). Sync pulses are exactly one pixel/line wide.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA shader stage: pixel strobe from a clock
// divider, pixel position, active flag, syncs, line/frame markers and frame count.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 5,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iENABLE,
  output logic        oPIX_EN,
  output logic [10:0] oX,
  output logic [10:0] oY,
  output logic        oACTIVE,
  output logic        oHSYNC,
  output logic        oVSYNC,
  output logic        oLINE_START,
  output logic        oFRAME_START,
  output logic [15:0] oFRAME_CNT
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d, v_q, v_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             pix_en_q, pix_en_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic             active_q, active_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic        tick;
  logic [10:0] h_nxt, v_nxt;

  // Next raster position; only committed on a tick.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    h_nxt = (h_q == H_LAST) ? 11'd0 : h_q + 11'd1;
    v_nxt = v_q;
    if (h_q == H_LAST) v_nxt = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
  end

  always_comb begin
    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    frame_cnt_d   = frame_cnt_q;
    pix_en_d      = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (!iENABLE) begin
      // Idle looks exactly like reset, except the frame count keeps running.
      div_d    = '0;
      h_d      = H_LAST;
      v_d      = V_LAST;
      x_d      = 11'd0;
      y_d      = 11'd0;
      active_d = 1'b0;
      hsync_d  = ~HS_POL;
      vsync_d  = ~VS_POL;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        h_d           = h_nxt;
        v_d           = v_nxt;
        pix_en_d      = 1'b1;
        x_d           = h_nxt;
        y_d           = v_nxt;
        active_d      = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hsync_d       = (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? HS_POL : ~HS_POL;
        vsync_d       = (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? VS_POL : ~VS_POL;
        line_start_d  = (h_nxt == 11'd0);
        frame_start_d = (h_nxt == 11'd0) && (v_nxt == 11'd0);
        if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  // Counters start at the last position so the first tick lands on (0,0)
  // and the frame count rolls over to 0 with it.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      div_q         <= '0;
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      frame_cnt_q   <= 16'hFFFF;
      pix_en_q      <= 1'b0;
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      active_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_cnt_q   <= frame_cnt_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign oPIX_EN      = pix_en_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oACTIVE      = active_q;
  assign oHSYNC       = hsync_q;
  assign oVSYNC       = vsync_q;
  assign oLINE_START  = line_start_q;
  assign oFRAME_START = frame_start_q;
  assign oFRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances checked every cycle
// against a pixel-index model under random enable drops and async resets.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_en;
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } vout_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic checking = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // DUT A: CLK_DIV=3, 15x9 raster, inverted vsync polarity
  logic        a_pix, a_act, a_hs, a_vs, a_ls, a_fs;
  logic [10:0] a_x, a_y;
  logic [15:0] a_fc;
  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1)
  ) u_a (
    .iCLK(clk), .iRESETn(rst_n), .iENABLE(en),
    .oPIX_EN(a_pix), .oX(a_x), .oY(a_y), .oACTIVE(a_act), .oHSYNC(a_hs),
    .oVSYNC(a_vs), .oLINE_START(a_ls), .oFRAME_START(a_fs), .oFRAME_CNT(a_fc)
  );

  // DUT B: CLK_DIV=1, minimal 5x4 raster, inverted hsync polarity
  logic        b_pix, b_act, b_hs, b_vs, b_ls, b_fs;
  logic [10:0] b_x, b_y;
  logic [15:0] b_fc;
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0)
  ) u_b (
    .iCLK(clk), .iRESETn(rst_n), .iENABLE(en),
    .oPIX_EN(b_pix), .oX(b_x), .oY(b_y), .oACTIVE(b_act), .oHSYNC(b_hs),
    .oVSYNC(b_vs), .oLINE_START(b_ls), .oFRAME_START(b_fs), .oFRAME_CNT(b_fc)
  );

  vout_t obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {a_pix, a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs, a_fc};
  assign obs_b = {b_pix, b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs, b_fc};

  // Reference: n = enabled edges since start; pixel index p = n/d - 1.
  function automatic vout_t model(int n, int d, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb,
                                  logic hp, logic vp, logic [15:0] fch);
    vout_t r;
    int ht, vt, p, xi, yi;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    r.pix_en = 1'b0; r.x = '0; r.y = '0; r.act = 1'b0;
    r.hs = ~hp; r.vs = ~vp; r.ls = 1'b0; r.fs = 1'b0; r.fc = fch;
    if (n >= d) begin
      p  = n / d - 1;
      xi = p % ht;
      yi = (p / ht) % vt;
      r.pix_en = ((n % d) == 0);
      r.x   = 11'(xi);
      r.y   = 11'(yi);
      r.act = (xi < ha) && (yi < va);
      r.hs  = (xi >= ha + hf && xi < ha + hf + hs) ? hp : ~hp;
      r.vs  = (yi >= va + vf && yi < va + vf + vs) ? vp : ~vp;
      r.ls  = r.pix_en && (xi == 0);
      r.fs  = r.ls && (yi == 0);
      r.fc  = 16'(int'(fch) + 1 + p / (ht * vt));
    end
    return r;
  endfunction

  int          n = 0;
  logic [15:0] fch_a = 16'hFFFF;
  logic [15:0] fch_b = 16'hFFFF;

  assign exp_a = model(n, 3, 8, 2, 3, 2, 5, 1, 2, 1, 1'b0, 1'b1, fch_a);
  assign exp_b = model(n, 1, 2, 1, 1, 1, 1, 1, 1, 1, 1'b1, 1'b0, fch_b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n     <= 0;
      fch_a <= 16'hFFFF;
      fch_b <= 16'hFFFF;
    end else if (!en) begin
      n     <= 0;
      fch_a <= exp_a.fc;
      fch_b <= exp_b.fc;
    end else begin
      n <= n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  task automatic cmp_out(input string who, input vout_t o, input vout_t e);
    chk({who, "_pix_en"}, 32'(o.pix_en), 32'(e.pix_en));
    chk({who, "_x"},      32'(o.x),      32'(e.x));
    chk({who, "_y"},      32'(o.y),      32'(e.y));
    chk({who, "_active"}, 32'(o.act),    32'(e.act));
    chk({who, "_hsync"},  32'(o.hs),     32'(e.hs));
    chk({who, "_vsync"},  32'(o.vs),     32'(e.vs));
    chk({who, "_lstart"}, 32'(o.ls),     32'(e.ls));
    chk({who, "_fstart"}, 32'(o.fs),     32'(e.fs));
    chk({who, "_fcnt"},   32'(o.fc),     32'(e.fc));
  endtask

  // Per-cycle checker plus aggregate counts on DUT A (40 active px/frame, 3 hsync px/line).
  initial begin
    int  act_cnt = 0, hs_cnt = 0;
    bit  have_frame = 0, have_line = 0;
    forever begin
      @(negedge clk);
      if (checking) begin
        cmp_out("A", obs_a, exp_a);
        cmp_out("B", obs_b, exp_b);
        if (!rst_n || !en) begin
          have_frame = 0;
          have_line  = 0;
        end else if (a_pix) begin
          if (a_fs) begin
            if (have_frame) chk("A_active_per_frame", 32'(act_cnt), 32'd40);
            have_frame = 1;
            act_cnt = 0;
          end
          if (a_ls) begin
            if (have_line) chk("A_hsync_per_line", 32'(hs_cnt), 32'd3);
            have_line = 1;
            hs_cnt = 0;
          end
          if (a_act) act_cnt++;
          if (a_hs == 1'b0) hs_cnt++;
        end
      end
    end
  end

  initial begin
    int t;
    #1 rst_n = 1'b0;
    en = 1'b1;
    #1 checking = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // First strobe of A lands 3 edges after release on (0,0), count 0.
    repeat (3) @(posedge clk);
    #1;
    chk("first_pix_en", 32'(a_pix), 32'd1);
    chk("first_fstart", 32'(a_fs), 32'd1);
    chk("first_fcnt", 32'(a_fc), 32'd0);
    chk("first_x", 32'(a_x), 32'd0);
    repeat (1000) @(posedge clk);

    // Run A to frame count 3, then hold enable low for 100 cycles.
    t = 0;
    while (a_fc != 16'd3 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_fcnt3", 32'(a_fc), 32'd3);
    en = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_fcnt", 32'(a_fc), 32'd3);
    chk("idle_pix_en", 32'(a_pix), 32'd0);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reen_fstart", 32'(a_fs), 32'd1);
    chk("reen_fcnt", 32'(a_fc), 32'd4);
    @(posedge clk);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0, 1: repeat ($urandom_range(50, 600)) @(posedge clk);
        2: begin
          #1 en = 1'b0;
          repeat ($urandom_range(1, 100)) @(posedge clk);
          #1 en = 1'b1;
          @(posedge clk);
        end
        default: begin
          #($urandom_range(1, 4)) rst_n = 1'b0;
          repeat ($urandom_range(1, 20)) @(posedge clk);
          #($urandom_range(1, 4)) rst_n = 1'b1;
          @(posedge clk);
        end
      endcase
    end
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
